// File: rtl/spi_regfile_gen.sv
// spi_regfile_gen: SPI mode-0 peripheral exposing NUM_REGS write-only control
// registers of DATA_W bits each. Frames are MSB first: R/W bit, ADDR_W address
// bits, then DATA_W data bits. All SPI pins are oversampled on clk.
// Optional feature macro: SPI_READBACK_EN builds the CIPO read-back path;
// without it, read frames are only length-checked and cipo/cipo_oe stay 0.
module spi_regfile_gen #(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         copi,
   input  logic                         ncs,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err,
   output logic [7:0]                   err_cnt
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   // Bits already held when the last address bit arrives
   localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_RDATA,
      S_OVERRUN,
      S_EVAL
   } state_t;

`ifdef SPI_READBACK_EN
   localparam state_t RD_NEXT = S_RDATA;
`else
   // Read frames still run through the data phase so they get length-checked
   localparam state_t RD_NEXT = S_DATA;
`endif

   // Synchronisers
   logic [2:0] sclk_q;
   logic [1:0] copi_q;
   logic [1:0] ncs_q;
   logic       ncs_prev_q;

   logic sclk_rise, ncs_rise, ncs_fall, copi_s;

   // Frame state
   state_t                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [ADDR_W-1:0]                cmd_q, cmd_d;
   logic [ADDR_W:0]                  cmd_full;
   logic [DATA_W-1:0]                data_q, data_d;
   logic                             rw_q, rw_d;
   logic                             ovr_q, ovr_d;
   logic                             frame_full, addr_ok;

   // Outputs
   logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
   logic                             wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
   logic                             frame_err_q, frame_err_d;
   logic [7:0]                       err_cnt_q, err_cnt_d;

   // Oversample the asynchronous SPI pins; ncs idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q     <= '0;
         copi_q     <= '0;
         ncs_q      <= 2'b11;
         ncs_prev_q <= 1'b1;
      end else begin
         sclk_q     <= {sclk_q[1:0], sclk};
         copi_q     <= {copi_q[0], copi};
         ncs_q      <= {ncs_q[0], ncs};
         ncs_prev_q <= ncs_q[1];
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign ncs_rise  = ncs_q[1] & ~ncs_prev_q;
   assign ncs_fall  = ~ncs_q[1] & ncs_prev_q;
   assign copi_s    = copi_q[1];

   // State, shift registers, register bank and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         data_q      <= '0;
         rw_q        <= 1'b0;
         ovr_q       <= 1'b0;
         regs_q      <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         rw_q        <= rw_d;
         ovr_q       <= ovr_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Frame FSM: bit shifting, frame evaluation and commit
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      rw_d        = rw_q;
      ovr_d       = ovr_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      cmd_full    = {cmd_q, copi_s};
      frame_full  = (cnt_q == CNT_FULL);
      addr_ok     = (int'(cmd_q) < NUM_REGS);

      // A new ncs falling edge during EVAL abandons the frame unevaluated
      if (state_q == S_EVAL && !ncs_fall) begin
         if (ovr_q || (cnt_q != '0 && !frame_full) || (frame_full && !addr_ok)) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF)
               err_cnt_d = err_cnt_q + 8'd1;
         end else if (frame_full && rw_q) begin
            for (int i = 0; i < NUM_REGS; i++)
               if (int'(cmd_q) == i)
                  regs_d[i] = data_q;
            wr_strobe_d = 1'b1;
            wr_addr_d   = cmd_q;
         end
      end

      // ncs edges take priority over any sclk edge seen in the same cycle
      if (ncs_fall) begin
         state_d = S_CMD;
         cnt_d   = '0;
         cmd_d   = '0;
         data_d  = '0;
         rw_d    = 1'b0;
         ovr_d   = 1'b0;
      end else if (ncs_rise && state_q != S_IDLE && state_q != S_EVAL) begin
         state_d = S_EVAL;
      end else begin
         case (state_q)
            S_CMD: begin
               if (sclk_rise) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  cmd_d = cmd_full[ADDR_W-1:0];
                  if (cnt_q == CNT_CMD) begin
                     rw_d    = cmd_full[ADDR_W];
                     state_d = cmd_full[ADDR_W] ? S_DATA : RD_NEXT;
                  end
               end
            end
            S_DATA, S_RDATA: begin
               if (sclk_rise) begin
                  if (frame_full) begin
                     state_d = S_OVERRUN;
                     ovr_d   = 1'b1;
                  end else begin
                     cnt_d  = cnt_q + CNT_W'(1);
                     data_d = DATA_W'({data_q, copi_s});
                  end
               end
            end
            S_EVAL:  state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   assign regs_flat = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;
   assign err_cnt   = err_cnt_q;

`ifdef SPI_READBACK_EN
   logic              sclk_fall;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
   logic              oe_q, oe_d;
   logic              cipo_q, cipo_d;

   assign sclk_fall = ~sclk_q[1] & sclk_q[2];

   // Read-out shifter: load on the first sclk fall after the address, shift on later falls
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(cmd_q) == i)
            rd_val = regs_q[i];
      rd_shift_d = rd_shift_q;
      oe_d       = oe_q;
      if (state_q == S_RDATA && sclk_fall) begin
         if (!oe_q) begin
            rd_shift_d = rd_val;
            oe_d       = 1'b1;
         end else begin
            rd_shift_d = rd_shift_q << 1;
         end
      end
      if (state_d != S_RDATA)
         oe_d = 1'b0;
      cipo_d = oe_d & rd_shift_d[DATA_W-1];
   end

   // Read-out registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_shift_q <= '0;
         oe_q       <= 1'b0;
         cipo_q     <= 1'b0;
      end else begin
         rd_shift_q <= rd_shift_d;
         oe_q       <= oe_d;
         cipo_q     <= cipo_d;
      end
   end

   assign cipo    = cipo_q;
   assign cipo_oe = oe_q;
`else
   assign cipo    = 1'b0;
   assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_gen.sv
// Directed bench for spi_regfile_gen: default instance plus two wide instances
// (NUM_REGS=16 and NUM_REGS=12, ADDR_W=4, DATA_W=16) sharing the SPI pins.
module tb_spi_regfile_gen;

`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, sclk, copi, ncs;

   logic         a_cipo, a_oe, a_strobe, a_ferr;
   logic [39:0]  a_regs;
   logic [6:0]   a_waddr;
   logic [7:0]   a_err;

   logic         b_cipo, b_oe, b_strobe, b_ferr;
   logic [255:0] b_regs;
   logic [3:0]   b_waddr;
   logic [7:0]   b_err;

   logic         c_cipo, c_oe, c_strobe, c_ferr;
   logic [191:0] c_regs;
   logic [3:0]   c_waddr;
   logic [7:0]   c_err;

   int passed = 0;
   int total  = 0;

   int a_strobes = 0, a_ferrs = 0, b_strobes = 0, c_ferrs = 0, wide_pulses = 0;
   logic a_strobe_prev = 1'b0, a_ferr_prev = 1'b0;

   spi_regfile_gen dut_a (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(a_cipo), .cipo_oe(a_oe), .regs_flat(a_regs), .wr_strobe(a_strobe),
      .wr_addr(a_waddr), .frame_err(a_ferr), .err_cnt(a_err)
   );

   spi_regfile_gen #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(b_cipo), .cipo_oe(b_oe), .regs_flat(b_regs), .wr_strobe(b_strobe),
      .wr_addr(b_waddr), .frame_err(b_ferr), .err_cnt(b_err)
   );

   spi_regfile_gen #(.NUM_REGS(12), .ADDR_W(4), .DATA_W(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(c_cipo), .cipo_oe(c_oe), .regs_flat(c_regs), .wr_strobe(c_strobe),
      .wr_addr(c_waddr), .frame_err(c_ferr), .err_cnt(c_err)
   );

   always #5 clk = ~clk;

   // Pulse counters and pulse-width monitor
   always @(negedge clk) begin
      if (a_strobe === 1'b1) a_strobes++;
      if (a_ferr === 1'b1)   a_ferrs++;
      if (b_strobe === 1'b1) b_strobes++;
      if (c_ferr === 1'b1)   c_ferrs++;
      if ((a_strobe === 1'b1 && a_strobe_prev) || (a_ferr === 1'b1 && a_ferr_prev))
         wide_pulses++;
      a_strobe_prev = (a_strobe === 1'b1);
      a_ferr_prev   = (a_ferr === 1'b1);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input int n, input logic [31:0] v);
      for (int i = n - 1; i >= 0; i--) begin
         copi = v[i];
         tick(8);
         sclk = 1'b1;
         tick(8);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input int n, input logic [31:0] v);
      ncs = 1'b0;
      tick(8);
      shift_bits(n, v);
      tick(8);
      ncs = 1'b1;
      tick(12);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      tick(4);
      total++; if (a_regs !== 40'h0) $display("FAIL reset_regs: got %h want 0", a_regs); else passed++;
      total++; if (a_cipo !== 1'b0 || a_oe !== 1'b0) $display("FAIL reset_cipo: got %b%b want 00", a_cipo, a_oe); else passed++;
      total++; if (a_strobe !== 1'b0 || a_ferr !== 1'b0) $display("FAIL reset_pulses: got %b%b want 00", a_strobe, a_ferr); else passed++;
      total++; if (a_waddr !== 7'h0) $display("FAIL reset_waddr: got %h want 0", a_waddr); else passed++;
      total++; if (a_err !== 8'h0) $display("FAIL reset_errcnt: got %h want 0", a_err); else passed++;
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic test_write_all;
      int s0;
      s0 = a_strobes;
      frame(16, 32'h80A5);
      frame(16, 32'h815A);
      frame(16, 32'h82FF);
      frame(16, 32'h8301);
      // Last write checked edge by edge for commit latency
      ncs = 1'b0;
      tick(8);
      shift_bits(16, 32'h8480);
      tick(8);
      ncs = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (a_strobe !== 1'b0 || a_regs[39:32] !== 8'h00) $display("FAIL latency_early: got strobe %b reg4 %h want 0 00", a_strobe, a_regs[39:32]); else passed++;
      @(posedge clk);
      @(negedge clk);
      total++; if (a_strobe !== 1'b1 || a_regs[39:32] !== 8'h80) $display("FAIL latency_commit: got strobe %b reg4 %h want 1 80", a_strobe, a_regs[39:32]); else passed++;
      @(negedge clk);
      total++; if (a_strobe !== 1'b0) $display("FAIL strobe_width: got %b want 0", a_strobe); else passed++;
      tick(10);
      total++; if (a_regs !== 40'h8001FF5AA5) $display("FAIL write_all_regs: got %h want 8001ff5aa5", a_regs); else passed++;
      total++; if (a_strobes - s0 !== 5) $display("FAIL write_all_strobes: got %0d want 5", a_strobes - s0); else passed++;
      total++; if (a_waddr !== 7'd4) $display("FAIL write_all_waddr: got %0d want 4", a_waddr); else passed++;
      total++; if (a_err !== 8'd0) $display("FAIL write_all_errcnt: got %0d want 0", a_err); else passed++;
   endtask

   task automatic test_bad_addr;
      int f0, s0;
      f0 = a_ferrs; s0 = a_strobes;
      frame(16, 32'h8533);
      total++; if (a_regs !== 40'h8001FF5AA5) $display("FAIL bad_addr_regs: got %h want 8001ff5aa5", a_regs); else passed++;
      total++; if (a_ferrs - f0 !== 1) $display("FAIL bad_addr_ferr: got %0d want 1", a_ferrs - f0); else passed++;
      total++; if (a_strobes - s0 !== 0) $display("FAIL bad_addr_strobe: got %0d want 0", a_strobes - s0); else passed++;
      total++; if (a_err !== 8'd1) $display("FAIL bad_addr_errcnt: got %0d want 1", a_err); else passed++;
   endtask

   task automatic test_short_long;
      int f0;
      f0 = a_ferrs;
      frame(15, 32'h40D5);
      frame(17, 32'h103DD);
      total++; if (a_regs[15:8] !== 8'h5A) $display("FAIL short_long_reg1: got %h want 5a", a_regs[15:8]); else passed++;
      total++; if (a_ferrs - f0 !== 2) $display("FAIL short_long_ferr: got %0d want 2", a_ferrs - f0); else passed++;
      total++; if (a_err !== 8'd3) $display("FAIL short_long_errcnt: got %0d want 3", a_err); else passed++;
   endtask

   task automatic test_readback;
      logic [15:0] rd;
      logic [7:0]  d;
      int f0;
      d  = 8'h3C;
      rd = 16'h0200;
      frame(16, 32'h823C);
      total++; if (a_regs[23:16] !== 8'h3C) $display("FAIL rb_write: got %h want 3c", a_regs[23:16]); else passed++;
      f0 = a_ferrs;
      ncs = 1'b0;
      tick(8);
      for (int i = 15; i >= 0; i--) begin
         copi = rd[i];
         tick(8);
         if (i == 8) begin
            total++; if (a_oe !== 1'b0) $display("FAIL rb_oe_before: got %b want 0", a_oe); else passed++;
         end
         if (i < 8) begin
            total++; if (a_cipo !== (RB & d[i])) $display("FAIL rb_cipo_bit%0d: got %b want %b", i, a_cipo, RB & d[i]); else passed++;
            total++; if (a_oe !== RB) $display("FAIL rb_oe_bit%0d: got %b want %b", i, a_oe, RB); else passed++;
         end
         sclk = 1'b1;
         tick(8);
         sclk = 1'b0;
      end
      tick(8);
      ncs = 1'b1;
      tick(12);
      total++; if (a_oe !== 1'b0 || a_cipo !== 1'b0) $display("FAIL rb_after: got oe %b cipo %b want 0 0", a_oe, a_cipo); else passed++;
      total++; if (a_regs !== 40'h80013C5AA5) $display("FAIL rb_regs: got %h want 80013c5aa5", a_regs); else passed++;
      total++; if (a_ferrs - f0 !== 0 || a_err !== 8'd3) $display("FAIL rb_noerr: got %0d/%0d want 0/3", a_ferrs - f0, a_err); else passed++;
   endtask

   task automatic test_abandon;
      int f0, s0;
      f0 = a_ferrs; s0 = a_strobes;
      ncs = 1'b0;
      tick(8);
      shift_bits(6, 32'h20);
      tick(8);
      // One-clk high glitch on ncs restarts the frame
      ncs = 1'b1;
      tick(1);
      ncs = 1'b0;
      tick(8);
      shift_bits(16, 32'h8377);
      tick(8);
      ncs = 1'b1;
      tick(12);
      total++; if (a_regs[31:24] !== 8'h77) $display("FAIL abandon_reg3: got %h want 77", a_regs[31:24]); else passed++;
      total++; if (a_ferrs - f0 !== 0) $display("FAIL abandon_ferr: got %0d want 0", a_ferrs - f0); else passed++;
      total++; if (a_strobes - s0 !== 1) $display("FAIL abandon_strobes: got %0d want 1", a_strobes - s0); else passed++;
      total++; if (a_waddr !== 7'd3 || a_err !== 8'd3) $display("FAIL abandon_status: got waddr %0d err %0d want 3 3", a_waddr, a_err); else passed++;
   endtask

   task automatic test_param_sweep;
      int sb, fc;
      sb = b_strobes; fc = c_ferrs;
      frame(21, {11'h0, 1'b1, 4'hF, 16'hBEEF});
      total++; if (b_regs[255:240] !== 16'hBEEF) $display("FAIL sweep_reg15: got %h want beef", b_regs[255:240]); else passed++;
      total++; if (b_regs[239:0] !== 240'h0) $display("FAIL sweep_others: got %h want 0", b_regs[239:0]); else passed++;
      total++; if (b_strobes - sb !== 1 || b_waddr !== 4'hF) $display("FAIL sweep_strobe: got %0d addr %h want 1 f", b_strobes - sb, b_waddr); else passed++;
      total++; if (c_ferrs - fc !== 1) $display("FAIL sweep_n12_ferr: got %0d want 1", c_ferrs - fc); else passed++;
      total++; if (c_regs !== 192'h0) $display("FAIL sweep_n12_regs: got %h want 0", c_regs); else passed++;
   endtask

   task automatic test_reset_mid_frame;
      int f0;
      ncs = 1'b0;
      tick(8);
      shift_bits(5, 32'h11);
      rst_n = 1'b0;
      ncs = 1'b1;
      sclk = 1'b0;
      tick(3);
      total++; if (a_regs !== 40'h0 || b_regs !== 256'h0) $display("FAIL midrst_regs: got %h want 0", a_regs); else passed++;
      total++; if (a_err !== 8'd0 || a_waddr !== 7'd0) $display("FAIL midrst_status: got err %0d waddr %0d want 0 0", a_err, a_waddr); else passed++;
      total++; if (a_strobe !== 1'b0 || a_ferr !== 1'b0 || a_cipo !== 1'b0 || a_oe !== 1'b0) $display("FAIL midrst_outs: got %b%b%b%b want 0000", a_strobe, a_ferr, a_cipo, a_oe); else passed++;
      f0 = a_ferrs;
      rst_n = 1'b1;
      tick(20);
      total++; if (a_err !== 8'd0 || a_ferrs - f0 !== 0) $display("FAIL midrst_after: got err %0d pulses %0d want 0 0", a_err, a_ferrs - f0); else passed++;
   endtask

   task automatic test_pulse_width;
      total++; if (wide_pulses !== 0) $display("FAIL pulse_width: got %0d wide pulses want 0", wide_pulses); else passed++;
   endtask

   initial begin
      test_reset();
      test_write_all();
      test_bad_addr();
      test_short_long();
      test_readback();
      test_abandon();
      test_param_sweep();
      test_reset_mid_frame();
      test_pulse_width();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spi_regfile_gen.md
# spi_regfile_gen

Parametrised SPI-mode-0 peripheral exposing a bank of NUM_REGS writable control registers, each DATA_W bits wide, to an external controller. It is the next-generation control-register front end of the design: a generalised, parametrised register file with frame-length checking, error reporting, a per-write strobe and optional register read-back on CIPO. All SPI pins are asynchronous to clk and oversampled; register outputs feed the output-enable and PWM blocks directly.

## Interface
- NUM_REGS, 5, number of registers; valid addresses 0..NUM_REGS-1 (1 ≤ NUM_REGS ≤ 2^ADDR_W)
- ADDR_W, 7, address field width
- DATA_W, 8, register and data field width
- FRAME_W (localparam), 1+ADDR_W+DATA_W, bits per frame
- clk  in  1  system clock; must be ≥ 8× SCLK
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock, async
- copi  in  1  controller-out data, async
- ncs  in  1  chip select, active-low, async
- cipo  out  1  peripheral-out data, registered
- cipo_oe  out  1  high while a read frame is driving cipo
- regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at [i*DATA_W +: DATA_W]
- wr_strobe  out  1  one-clk pulse on each committed write
- wr_addr  out  ADDR_W  address of last committed write
- frame_err  out  1  one-clk pulse on a discarded frame
- err_cnt  out  8  count of discarded frames, saturates at 255

## Operation
- Sync: sclk through 3 flops (edge detect on last two), copi and ncs through 2 flops. All logic uses synchronised signals only.
- Frame, MSB first, sampled on sclk rising: bit 0 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- FSM states:
  - IDLE: entered at reset. ncs falling → CMD; clear shift register and bit counter.
  - CMD: shift 1+ADDR_W bits. At the last address bit: write → DATA; read → RDATA.
  - DATA: shift DATA_W bits.
  - RDATA: capture copi bits as in DATA (data is ignored) and drive cipo.
  - Any state: ncs rising → EVAL. A further sclk rising edge once FRAME_W bits are held → OVERRUN.
  - OVERRUN: ignore sclk until ncs rising → EVAL.
  - EVAL: one cycle, → IDLE.
- EVAL write commit requires all of: bit count == FRAME_W, not overrun, write bit set, address < NUM_REGS. On commit: update the addressed register, pulse wr_strobe, set wr_addr.
- Discards:
  - Short frame, overrun or address ≥ NUM_REGS: pulse frame_err and increment err_cnt (saturating). No register changes.
  - A complete, valid read frame is not an error.
  - Zero-length frame (ncs low then high with no sclk): silently ignored, not an error.
- ncs falling while not in IDLE: abandon the current frame without evaluating it and restart at CMD.
- Simultaneous ncs rising and sclk rising in the same clk cycle: ncs wins; that sclk edge is not counted.
- Registers are width-exact. Data field bits above DATA_W do not exist; the address is compared unsigned at full ADDR_W.

## Timing
- Reset values: regs_flat 0, cipo 0, cipo_oe 0, wr_strobe 0, wr_addr 0, frame_err 0, err_cnt 0, FSM in IDLE.
- Reset mid-frame: frame dropped, nothing committed or counted.
- Write latency: regs_flat, wr_strobe, wr_addr and frame_err update on the 4th clk rising edge after the first edge that samples the ncs pin high (2 sync + 1 detect + 1 commit).
- wr_strobe and frame_err are exactly one clk wide.
- Read, with SPI_READBACK_EN:
  - On the first synchronised sclk falling edge after the last address bit, load reg[addr] (0 if address is invalid) and assert cipo_oe.
  - cipo presents the MSB 1 clk after that detection.
  - Each subsequent sclk falling edge shifts out the next bit.
  - cipo_oe and cipo return to 0 on the clk after ncs rising is detected.
- Reads never modify any register.

## Configuration
- SPI_READBACK_EN defined: RDATA state active; cipo and cipo_oe behave as above.
- SPI_READBACK_EN undefined: cipo and cipo_oe tied 0; the read-out shift register is not built. Read frames are still length-checked; valid read frames are ignored and short or overrun read frames still count as errors.

## Test plan
- Reset then write frames addr 0..4 with data 0xA5,0x5A,0xFF,0x01,0x80 (default params) → each regs_flat slice equals its data, 5 wr_strobe pulses, wr_addr = 4, err_cnt = 0.
- Write to addr 5 data 0x33 → no register change, one frame_err pulse, err_cnt = 1.
- 15-bit frame, then 17-bit frame, each writing addr 1 → register 1 unchanged, err_cnt += 2.
- With SPI_READBACK_EN, after writing 0x3C to addr 2, read addr 2 → cipo bits 0,0,1,1,1,1,0,0 on the eight data clocks, cipo_oe high only inside the frame; without the macro cipo stays 0.
- ncs deasserted and reasserted after 6 bits, then a full write of 0x77 to addr 3 → only 0x77 committed, no frame_err; rst_n pulsed mid-frame → all outputs return to reset values.
- Parameter sweep NUM_REGS=16, DATA_W=16, ADDR_W=4 → write 0xBEEF to addr 15 lands at regs_flat[255:240]; write to addr 15 with NUM_REGS=12 → frame_err.
